// File: rtl/tdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tdc_pkg : shared constants and FSM state type for the TDC post-processing path
// | Rev 1.0
// +----------------------------------------------------------------------------
package tdc_pkg;

  localparam int                TDC_DW       = 6;
  localparam logic [TDC_DW-1:0] TDC_CODE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tdc_code_avg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tdc_code_avg_if : control, sample and result signals of the code averager
// | Rev 1.0
// +----------------------------------------------------------------------------
interface tdc_code_avg_if
  import tdc_pkg::*;
#(
  parameter int DW       = TDC_DW,
  parameter int AVG_LOG2 = 3,
  parameter int SCNT_W   = 8
);

  logic                   en;
  logic                   clr_stat;
  logic                   tdc_vld;
  logic [DW-1:0]          tdc_code;
  logic                   avg_vld;
  logic [DW+AVG_LOG2-1:0] avg_sum;
  logic [DW-1:0]          code_min;
  logic [DW-1:0]          code_max;
  logic [SCNT_W-1:0]      sat_cnt;
  logic                   filled;

  modport master (
    output en, clr_stat, tdc_vld, tdc_code,
    input  avg_vld, avg_sum, code_min, code_max, sat_cnt, filled
  );

  modport slave (
    input  en, clr_stat, tdc_vld, tdc_code,
    output avg_vld, avg_sum, code_min, code_max, sat_cnt, filled
  );

endinterface
`default_nettype wire

// File: rtl/tdc_win_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tdc_win_buf : N x DW circular window store, one write port, async read at addr
// | Rev 1.0
// +----------------------------------------------------------------------------
module tdc_win_buf #(
  parameter int DW = 6,
  parameter int AW = 3
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] addr,
  input  wire logic [DW-1:0] wdata,
  output logic      [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read returns the oldest sample, i.e. the one about to be overwritten.
  assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/tdc_code_avg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tdc_code_avg : boxcar moving sum, min/max and saturation stats of TDC codes
// | Rev 1.0
// +----------------------------------------------------------------------------
module tdc_code_avg
  import tdc_pkg::*;
#(
  parameter int DW       = TDC_DW,
  parameter int AVG_LOG2 = 3,
  parameter int SCNT_W   = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  tdc_code_avg_if.slave bus
);

  localparam int                SW         = DW + AVG_LOG2;
  localparam int                FW         = AVG_LOG2 + 1;
  localparam logic [FW-1:0]     C_LAST     = FW'((2**AVG_LOG2) - 1);
  localparam logic [DW-1:0]     C_CODE_MAX = '1;
  localparam logic [SCNT_W-1:0] C_SAT_MAX  = '1;

  state_e              state_q, state_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2-1:0] wptr_q, wptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                avg_vld_q, avg_vld_d;
  logic [SW-1:0]       avg_sum_q, avg_sum_d;
  logic [DW-1:0]       min_q, min_d;
  logic [DW-1:0]       max_q, max_d;
  logic [SCNT_W-1:0]   sat_q, sat_d;

  logic                accept;
  logic [DW-1:0]       old_code;
  logic [SW-1:0]       code_ext;
  logic [SW-1:0]       old_ext;
  logic                code_sat;
  logic [DW-1:0]       min_base;
  logic [DW-1:0]       max_base;
  logic [SCNT_W-1:0]   sat_base;

  assign accept   = bus.tdc_vld && bus.en && (state_q != ST_IDLE);
  assign code_ext = {{AVG_LOG2{1'b0}}, bus.tdc_code};
  assign old_ext  = {{AVG_LOG2{1'b0}}, old_code};
  assign code_sat = (bus.tdc_code == '0) || (bus.tdc_code == C_CODE_MAX);

  tdc_win_buf #(
    .DW (DW),
    .AW (AVG_LOG2)
  ) u_win_buf (
    .clk   (clk),
    .we    (accept && !rst),
    .addr  (wptr_q),
    .wdata (bus.tdc_code),
    .rdata (old_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      avg_vld_q <= 1'b0;
      avg_sum_q <= '0;
      min_q     <= C_CODE_MAX;
      max_q     <= '0;
      sat_q     <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      avg_vld_q <= avg_vld_d;
      avg_sum_q <= avg_sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    avg_vld_d = 1'b0;
    avg_sum_d = avg_sum_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          sum_d  = sum_q + code_ext;
          wptr_d = wptr_q + AVG_LOG2'(1);
          fill_d = fill_q + FW'(1);
          if (fill_q == C_LAST) begin
            state_d   = ST_RUN;
            avg_vld_d = 1'b1;
            avg_sum_d = sum_d;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          // Modular arithmetic in SW bits is exact: the true sum always fits.
          sum_d     = sum_q - old_ext + code_ext;
          wptr_d    = wptr_q + AVG_LOG2'(1);
          avg_vld_d = 1'b1;
          avg_sum_d = sum_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!bus.en) begin
      state_d   = ST_IDLE;
      sum_d     = '0;
      wptr_d    = '0;
      fill_d    = '0;
      avg_vld_d = 1'b0;
      avg_sum_d = '0;
    end
  end

  // A clear that coincides with a sample is applied first, then the sample.
  always_comb begin
    min_base = bus.clr_stat ? C_CODE_MAX : min_q;
    max_base = bus.clr_stat ? '0 : max_q;
    sat_base = bus.clr_stat ? '0 : sat_q;
    min_d    = min_base;
    max_d    = max_base;
    sat_d    = sat_base;
    if (accept) begin
      if (bus.tdc_code < min_base) begin
        min_d = bus.tdc_code;
      end
      if (bus.tdc_code > max_base) begin
        max_d = bus.tdc_code;
      end
      if (code_sat && (sat_base != C_SAT_MAX)) begin
        sat_d = sat_base + SCNT_W'(1);
      end
    end
  end

  assign bus.avg_vld  = avg_vld_q;
  assign bus.avg_sum  = avg_sum_q;
  assign bus.code_min = min_q;
  assign bus.code_max = max_q;
  assign bus.sat_cnt  = sat_q;
  assign bus.filled   = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_tdc_code_avg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_tdc_code_avg : directed self-checking bench for tdc_code_avg
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_tdc_code_avg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tdc_code_avg_if #(.DW(6), .AVG_LOG2(3), .SCNT_W(8)) tif ();

  tdc_code_avg #(
    .DW       (6),
    .AVG_LOG2 (3),
    .SCNT_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample per two cycles; returns the outputs seen the cycle after acceptance.
  task automatic push(input logic [5:0] code, output logic vld_seen, output logic [8:0] sum_seen);
    @(negedge clk);
    tif.tdc_vld  = 1'b1;
    tif.tdc_code = code;
    @(negedge clk);
    tif.tdc_vld  = 1'b0;
    vld_seen     = tif.avg_vld;
    sum_seen     = tif.avg_sum;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       v;
    logic [8:0] s;
    int         vld_cnt;
    int         exp_sums [4];

    exp_sums     = '{176, 192, 208, 224};
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    tif.en       = 1'b0;
    tif.clr_stat = 1'b0;
    tif.tdc_vld  = 1'b0;
    tif.tdc_code = '0;

    // Reset with sample valid toggling
    vld_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tif.tdc_vld  = ~tif.tdc_vld;
      tif.tdc_code = 6'd63;
      vld_cnt += int'(tif.avg_vld);
    end
    @(negedge clk);
    check("rst_avg_vld", {31'd0, tif.avg_vld}, 32'd0);
    check("rst_avg_sum", {23'd0, tif.avg_sum}, 32'd0);
    check("rst_min", {26'd0, tif.code_min}, 32'd63);
    check("rst_max", {26'd0, tif.code_max}, 32'd0);
    check("rst_sat", {24'd0, tif.sat_cnt}, 32'd0);
    check("rst_filled", {31'd0, tif.filled}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tif.tdc_vld = ~tif.tdc_vld;
      vld_cnt += int'(tif.avg_vld);
    end
    tif.tdc_vld = 1'b0;
    check("idle_no_avg_vld", vld_cnt, 0);
    check("idle_sat", {24'd0, tif.sat_cnt}, 32'd0);
    check("idle_min", {26'd0, tif.code_min}, 32'd63);

    // Fill with eight samples of 20
    @(negedge clk);
    tif.en  = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      push(6'd20, v, s);
      vld_cnt += int'(v);
    end
    check("fill_no_vld", vld_cnt, 0);
    check("fill_not_filled", {31'd0, tif.filled}, 32'd0);
    push(6'd20, v, s);
    check("fill_vld", {31'd0, v}, 32'd1);
    check("fill_sum", {23'd0, s}, 32'd160);
    check("fill_filled", {31'd0, tif.filled}, 32'd1);
    @(negedge clk);
    check("vld_pulse_len", {31'd0, tif.avg_vld}, 32'd0);
    check("sum_holds", {23'd0, tif.avg_sum}, 32'd160);

    // Slide in four samples of 36
    for (int i = 0; i < 4; i++) begin
      push(6'd36, v, s);
      check("slide_vld", {31'd0, v}, 32'd1);
      check("slide_sum", {23'd0, s}, exp_sums[i]);
    end
    check("slide_min", {26'd0, tif.code_min}, 32'd20);
    check("slide_max", {26'd0, tif.code_max}, 32'd36);

    // Saturating codes: window [36 x4, 20 x4], oldest 20s get replaced
    push(6'd0, v, s);
    check("sat0_sum", {23'd0, s}, 32'd204);
    push(6'd63, v, s);
    check("sat63_sum", {23'd0, s}, 32'd247);
    push(6'd0, v, s);
    check("sat_sum", {23'd0, s}, 32'd227);
    check("sat_cnt3", {24'd0, tif.sat_cnt}, 32'd3);
    check("sat_min", {26'd0, tif.code_min}, 32'd0);
    check("sat_max", {26'd0, tif.code_max}, 32'd63);
    for (int i = 0; i < 300; i++) begin
      push(6'd0, v, s);
    end
    check("sat_cnt_stick", {24'd0, tif.sat_cnt}, 32'd255);
    check("zero_window_sum", {23'd0, s}, 32'd0);

    // Clear coincident with a sample of 17
    @(negedge clk);
    tif.clr_stat = 1'b1;
    tif.tdc_vld  = 1'b1;
    tif.tdc_code = 6'd17;
    @(negedge clk);
    tif.clr_stat = 1'b0;
    tif.tdc_vld  = 1'b0;
    check("clr_min", {26'd0, tif.code_min}, 32'd17);
    check("clr_max", {26'd0, tif.code_max}, 32'd17);
    check("clr_sat", {24'd0, tif.sat_cnt}, 32'd0);
    check("clr_sum", {23'd0, tif.avg_sum}, 32'd17);

    // Drop EN from RUN, then refill partially and drop again
    tif.en = 1'b0;
    @(negedge clk);
    check("drop_run_sum", {23'd0, tif.avg_sum}, 32'd0);
    check("drop_run_filled", {31'd0, tif.filled}, 32'd0);
    tif.en  = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      push(6'd10, v, s);
      vld_cnt += int'(v);
    end
    check("partial_no_vld", vld_cnt, 0);
    tif.en = 1'b0;
    @(negedge clk);
    check("drop_fill_sum", {23'd0, tif.avg_sum}, 32'd0);
    check("drop_fill_filled", {31'd0, tif.filled}, 32'd0);
    check("drop_keep_min", {26'd0, tif.code_min}, 32'd10);
    check("drop_keep_max", {26'd0, tif.code_max}, 32'd17);
    tif.en  = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      push(6'd5, v, s);
      vld_cnt += int'(v);
    end
    check("refill_no_vld", vld_cnt, 0);
    push(6'd5, v, s);
    check("refill_vld", {31'd0, v}, 32'd1);
    check("refill_sum", {23'd0, s}, 32'd40);
    check("refill_filled", {31'd0, tif.filled}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
